// File: rtl/f1_reaction_timer.sv
`default_nettype none
// ============================================================================
// Module   : f1_reaction_timer
// Brief    : Detects F1 "lights out" and counts 1 ms ticks until the driver
//            presses the button. Also flags false starts and timeouts.
//            The optional best-time register is built when REACT_BEST_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module f1_reaction_timer #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 10,
    parameter int MAX_MS     = 999
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic [DATA_WIDTH-1:0] lights,
    input  logic                  button,
    output logic [CNT_WIDTH-1:0]  react_time,
    output logic                  valid,
    output logic                  false_start,
    output logic                  timeout,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  best_time
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_ARMED  = 3'd1;
    localparam logic [2:0] c_TIMING = 3'd2;
    localparam logic [2:0] c_DONE   = 3'd3;
    localparam logic [2:0] c_FALSE  = 3'd4;
    localparam logic [2:0] c_TOUT   = 3'd5;

    localparam logic [CNT_WIDTH-1:0] c_MAX = CNT_WIDTH'(MAX_MS);

    logic [2:0]           r_state, w_state_nxt;
    logic [CNT_WIDTH-1:0] r_count, w_count_nxt;
    logic [CNT_WIDTH-1:0] r_react_time, w_react_nxt;
    logic                 r_valid, w_valid_nxt;
    logic                 r_false_start, w_fs_nxt;
    logic                 r_timeout, w_to_nxt;
    logic                 r_seen_full, w_seen_nxt;
    logic                 r_sync1, r_sync2, r_sync3;
    logic                 w_press;
    logic                 w_lights_zero;
    logic                 w_lights_full;
    logic [CNT_WIDTH-1:0] w_count_inc;

    assign w_press       = r_sync2 & ~r_sync3;
    assign w_lights_zero = (lights == '0);
    assign w_lights_full = (lights == '1);
    assign w_count_inc   = r_count + CNT_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= button;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= c_IDLE;
            r_count       <= '0;
            r_react_time  <= '0;
            r_valid       <= 1'b0;
            r_false_start <= 1'b0;
            r_timeout     <= 1'b0;
            r_seen_full   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_count       <= w_count_nxt;
            r_react_time  <= w_react_nxt;
            r_valid       <= w_valid_nxt;
            r_false_start <= w_fs_nxt;
            r_timeout     <= w_to_nxt;
            r_seen_full   <= w_seen_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_react_nxt = r_react_time;
        w_valid_nxt = 1'b0;
        w_fs_nxt    = r_false_start;
        w_to_nxt    = r_timeout;
        w_seen_nxt  = r_seen_full;
        case (r_state)
            c_IDLE: begin
                if (!w_lights_zero) begin
                    w_state_nxt = c_ARMED;
                    w_fs_nxt    = 1'b0;
                    w_to_nxt    = 1'b0;
                    w_seen_nxt  = 1'b0;
                end
            end
            c_ARMED: begin
                // An early press outranks lights out arriving in the same cycle
                if (w_press) begin
                    w_state_nxt = c_FALSE;
                    w_fs_nxt    = 1'b1;
                    w_react_nxt = '0;
                end else if (w_lights_zero) begin
                    if (r_seen_full) begin
                        w_state_nxt = c_TIMING;
                        w_count_nxt = '0;
                    end else begin
                        w_state_nxt = c_IDLE;
                    end
                end else if (w_lights_full) begin
                    w_seen_nxt = 1'b1;
                end
            end
            c_TIMING: begin
                if (w_press) begin
                    w_state_nxt = c_DONE;
                    w_react_nxt = r_count;
                    w_valid_nxt = 1'b1;
                end else if (tick) begin
                    w_count_nxt = w_count_inc;
                    if (w_count_inc == c_MAX) begin
                        w_state_nxt = c_TOUT;
                        w_react_nxt = c_MAX;
                        w_to_nxt    = 1'b1;
                    end
                end
            end
            c_DONE, c_FALSE, c_TOUT: begin
                if (!w_lights_zero) begin
                    w_state_nxt = c_ARMED;
                    w_fs_nxt    = 1'b0;
                    w_to_nxt    = 1'b0;
                    w_seen_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    assign react_time  = r_react_time;
    assign valid       = r_valid;
    assign false_start = r_false_start;
    assign timeout     = r_timeout;
    assign busy        = (r_state == c_ARMED) || (r_state == c_TIMING);

`ifdef REACT_BEST_EN
    logic [CNT_WIDTH-1:0] r_best;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_best <= '1;
        end else if (w_valid_nxt && (w_react_nxt < r_best)) begin
            r_best <= w_react_nxt;
        end
    end

    assign best_time = r_best;
`else
    assign best_time = '1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_f1_reaction_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_f1_reaction_timer
// Brief    : Directed and randomized checks of f1_reaction_timer against a
//            simple reaction-time model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_f1_reaction_timer;

    localparam int DW  = 8;
    localparam int CW  = 10;
    localparam int MAX = 999;

    logic          clk;
    logic          rst;
    logic          tick;
    logic [DW-1:0] lights;
    logic          button;
    logic [CW-1:0] react_time;
    logic          valid;
    logic          false_start;
    logic          timeout;
    logic          busy;
    logic [CW-1:0] best_time;

    int checks;
    int failures;
    int valid_cnt;

    int exp_react;
    int exp_best;

    f1_reaction_timer #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW),
        .MAX_MS     (MAX)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .lights      (lights),
        .button      (button),
        .react_time  (react_time),
        .valid       (valid),
        .false_start (false_start),
        .timeout     (timeout),
        .busy        (busy),
        .best_time   (best_time)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid) valid_cnt <= valid_cnt + 1;
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_best_out();
`ifdef REACT_BEST_EN
        return exp_best;
`else
        return (1 << CW) - 1;
`endif
    endfunction

    // Ramp the bar up to all-lit and hold it, leaving the block ARMED
    task automatic ramp_full();
        logic [DW-1:0] v;
        v = '0;
        for (int i = 0; i < DW; i++) begin
            v = {v[DW-2:0], 1'b1};
            lights = v;
            step();
        end
        step();
    endtask

    task automatic lights_out();
        lights = '0;
        step();
    endtask

    task automatic send_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            repeat ($urandom_range(0, 2)) step();
        end
    endtask

    // Press the button with no ticks around it; expect a measurement of n
    task automatic press_measure(input string tag, input int n);
        int vc0;
        exp_react = n;
        if (n < exp_best) exp_best = n;
        button = 1'b1;
        step();
        step();
        step();
        check({tag, "_react"}, react_time, exp_react);
        check({tag, "_valid"}, valid, 1);
        button = 1'b0;
        step();
        vc0 = valid_cnt;
        check({tag, "_valid_drop"}, valid, 0);
        step();
        check({tag, "_busy"}, busy, 0);
        check({tag, "_best"}, best_time, exp_best_out());
        check({tag, "_one_pulse"}, valid_cnt - vc0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
        exp_react = 0;
        exp_best  = (1 << CW) - 1;
    endtask

    initial begin
        int n;
        int vc;
        checks    = 0;
        failures  = 0;
        valid_cnt = 0;
        tick      = 1'b0;
        button    = 1'b0;
        lights    = '0;
        rst       = 1'b0;
        exp_react = 0;
        exp_best  = (1 << CW) - 1;
        step();
        step();
        check("rst_react", react_time, 0);
        check("rst_valid", valid, 0);
        check("rst_fs", false_start, 0);
        check("rst_to", timeout, 0);
        check("rst_busy", busy, 0);
        check("rst_best", best_time, (1 << CW) - 1);
        rst = 1'b1;
        step();

        // Normal reaction of 250 ticks
        ramp_full();
        check("arm_busy", busy, 1);
        lights_out();
        check("timing_busy", busy, 1);
        send_ticks(250);
        press_measure("norm250", 250);
        check("norm_fs", false_start, 0);
        check("norm_to", timeout, 0);

        // Press edge coincident with a tick at count 41
        ramp_full();
        lights_out();
        send_ticks(41);
        button = 1'b1;
        step();
        step();
        tick = 1'b1;
        step();
        tick = 1'b0;
        exp_react = 41;
        if (41 < exp_best) exp_best = 41;
        check("coinc_react", react_time, exp_react);
        check("coinc_valid", valid, 1);
        button = 1'b0;
        step();
        step();

        // Randomized reaction runs
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 400);
            ramp_full();
            lights_out();
            send_ticks(n);
            press_measure("rand", n);
        end

        // Aborted sequence never reaches all-lit
        lights = 8'h01;
        step();
        check("abort_busy_armed", busy, 1);
        lights = 8'h07;
        step();
        lights = 8'h00;
        step();
        check("abort_busy", busy, 0);
        check("abort_react", react_time, exp_react);

        // False start: press while lights are all lit
        ramp_full();
        vc = valid_cnt;
        button = 1'b1;
        step();
        step();
        step();
        exp_react = 0;
        check("fs_flag", false_start, 1);
        check("fs_react", react_time, exp_react);
        check("fs_busy", busy, 0);
        lights_out();
        step();
        check("fs_hold", false_start, 1);
        check("fs_busy_hold", busy, 0);
        check("fs_no_valid", valid_cnt - vc, 0);
        button = 1'b0;
        step();
        step();

        // Press lands in the same cycle as lights FF->00
        lights = 8'h01;
        step();
        check("rearm_fs_clear", false_start, 0);
        ramp_full();
        button = 1'b1;
        step();
        step();
        lights = '0;
        step();
        check("fs_coinc_flag", false_start, 1);
        check("fs_coinc_busy", busy, 0);
        button = 1'b0;
        step();
        step();

        // Timeout after MAX ticks without a press
        ramp_full();
        lights_out();
        vc = valid_cnt;
        send_ticks(MAX - 1);
        check("to_before", timeout, 0);
        check("to_busy_before", busy, 1);
        send_ticks(1);
        exp_react = MAX;
        check("to_flag", timeout, 1);
        check("to_react", react_time, exp_react);
        check("to_busy", busy, 0);
        button = 1'b1;
        repeat (4) step();
        button = 1'b0;
        step();
        check("to_press_ignored", react_time, exp_react);
        check("to_no_valid", valid_cnt - vc, 0);
        check("to_hold", timeout, 1);

        // Best time over three runs since a fresh reset
        do_reset();
        step();
        check("best_rst", best_time, (1 << CW) - 1);
        ramp_full();
        check("rearm_to_clear", timeout, 0);
        lights_out();
        send_ticks(300);
        press_measure("best300", 300);
        ramp_full();
        lights_out();
        send_ticks(180);
        press_measure("best180", 180);
        ramp_full();
        lights_out();
        send_ticks(220);
        press_measure("best220", 220);
        check("best_final", best_time, exp_best_out());

        // Reset in the middle of a measurement
        ramp_full();
        lights_out();
        send_ticks(17);
        rst = 1'b0;
        step();
        check("mid_rst_busy", busy, 0);
        check("mid_rst_react", react_time, 0);
        check("mid_rst_valid", valid, 0);
        check("mid_rst_fs", false_start, 0);
        check("mid_rst_to", timeout, 0);
        check("mid_rst_best", best_time, (1 << CW) - 1);
        rst = 1'b1;
        step();
        step();
        check("post_rst_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
